amci_arbiter: RTL

- Shares one AMCI-driven AXI4-Lite master between NUM_REQ independent requesters.
- Each requester sees a private AMCI_MOSI/AMCI_MISO pair with the same protocol the master presents: one-cycle write/read pulse, then wait for idle.
- Write and read channels are arbitrated independently, each round-robin, matching the master's independent write and read FSMs.
- Sits between user logic (register sequencers, DMA setup engines) and the single AXI4-Lite master.

---
 rtl/amci_pkg.sv | 38 +++
 rtl/amci_rr_arbiter.sv | 47 ++++
 rtl/amci_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/amci_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : amci_pkg
//  Purpose  : Shared AMCI bit layout and FSM state encodings for the
//             AMCI requester arbiter.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package amci_pkg;

  // AMCI_MOSI field offsets
  localparam int WADDR  = 0;
  localparam int WDATA  = 32;
  localparam int RADDR  = 64;
  localparam int WRITE  = 96;
  localparam int READ   = 97;
  localparam int MOSI_W = 98;

  // AMCI_MISO field offsets
  localparam int RDATA  = 0;
  localparam int WIDLE  = 32;
  localparam int RIDLE  = 33;
  localparam int MISO_W = 34;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_WAIT  = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/amci_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : amci_rr_arbiter
//  Purpose  : Combinational round-robin picker. The search starts at ptr and
//             wraps; the first set request bit wins.
//  Ports    : req       - request vector (NUM_REQ bits)
//             ptr       - index the search starts from
//             grant     - one-hot grant (all zero when no request)
//             grant_idx - encoded grant index
//  Revision : 1.0  initial release
// ============================================================================
module amci_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int               w_pos;
  logic [IDX_W-1:0] w_sel;

  // Walk the offsets from farthest to nearest so the nearest pending
  // requester (relative to ptr) is the last, and therefore winning, assignment.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_pos     = 0;
    w_sel     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      w_sel = IDX_W'(w_pos);
      if (req[w_sel]) begin
        grant        = '0;
        grant[w_sel] = 1'b1;
        grant_idx    = w_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/amci_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : amci_arbiter
//  Purpose  : Shares one AMCI-driven AXI4-Lite master between NUM_REQ
//             requesters. Write and read channels are arbitrated
//             independently, each round-robin.
//  Ports    : M_AXI_ACLK    - clock (same as the AXI4-Lite master)
//             M_AXI_ARESETN - asynchronous active-low reset
//             REQ_MOSI      - requester i at [98*i +: 98]
//             REQ_MISO      - requester i at [34*i +: 34]
//             AMCI_MOSI     - to the master
//             AMCI_MISO     - from the master
//  Revision : 1.0  initial release
// ============================================================================
module amci_arbiter
  import amci_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic [NUM_REQ*MOSI_W-1:0] REQ_MOSI,
  output logic [NUM_REQ*MISO_W-1:0] REQ_MISO,
  output logic [MOSI_W-1:0]         AMCI_MOSI,
  input  logic [MISO_W-1:0]         AMCI_MISO
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Requester-side views
  logic [NUM_REQ-1:0]        w_wr_in, w_rd_in;
  logic [AXI_ADDR_WIDTH-1:0] w_waddr_in [NUM_REQ];
  logic [AXI_DATA_WIDTH-1:0] w_wdata_in [NUM_REQ];
  logic [AXI_ADDR_WIDTH-1:0] w_raddr_in [NUM_REQ];

  // Per-requester state
  logic [NUM_REQ-1:0]        r_pend_w, r_pend_r;
  logic [AXI_ADDR_WIDTH-1:0] r_waddr [NUM_REQ];
  logic [AXI_DATA_WIDTH-1:0] r_wdata [NUM_REQ];
  logic [AXI_ADDR_WIDTH-1:0] r_raddr [NUM_REQ];
  logic [AXI_DATA_WIDTH-1:0] r_rdata [NUM_REQ];

  // Master-side view
  logic                      w_m_widle, w_m_ridle;
  logic [AXI_DATA_WIDTH-1:0] w_m_rdata;

  // Downstream registers
  logic [AXI_ADDR_WIDTH-1:0] r_dn_waddr, r_dn_raddr;
  logic [AXI_DATA_WIDTH-1:0] r_dn_wdata;
  logic                      r_dn_write, r_dn_read;

  // Channel control
  wr_state_t          r_w_state, w_w_state_nxt;
  rd_state_t          r_r_state, w_r_state_nxt;
  logic [IDX_W-1:0]   r_w_ptr, r_r_ptr, r_w_idx, r_r_idx;
  logic [NUM_REQ-1:0] r_w_gnt, r_r_gnt;
  logic [NUM_REQ-1:0] w_w_gnt, w_r_gnt;
  logic [IDX_W-1:0]   w_w_gnt_idx, w_r_gnt_idx;
  logic               w_w_load, w_w_done, w_r_load, w_r_done;
  logic [NUM_REQ-1:0] w_cap_w, w_cap_r, w_clr_w, w_clr_r;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_wr_in[gi]    = REQ_MOSI[MOSI_W*gi + WRITE];
      assign w_rd_in[gi]    = REQ_MOSI[MOSI_W*gi + READ];
      assign w_waddr_in[gi] = REQ_MOSI[MOSI_W*gi + WADDR +: AXI_ADDR_WIDTH];
      assign w_wdata_in[gi] = REQ_MOSI[MOSI_W*gi + WDATA +: AXI_DATA_WIDTH];
      assign w_raddr_in[gi] = REQ_MOSI[MOSI_W*gi + RADDR +: AXI_ADDR_WIDTH];

      assign REQ_MISO[MISO_W*gi + RDATA +: AXI_DATA_WIDTH] = r_rdata[gi];
      assign REQ_MISO[MISO_W*gi + WIDLE] = !r_pend_w[gi] && !w_wr_in[gi];
      assign REQ_MISO[MISO_W*gi + RIDLE] = !r_pend_r[gi] && !w_rd_in[gi];
    end
  endgenerate

  assign w_m_widle = AMCI_MISO[WIDLE];
  assign w_m_ridle = AMCI_MISO[RIDLE];
  assign w_m_rdata = AMCI_MISO[RDATA +: AXI_DATA_WIDTH];

  assign AMCI_MOSI[WADDR +: AXI_ADDR_WIDTH] = r_dn_waddr;
  assign AMCI_MOSI[WDATA +: AXI_DATA_WIDTH] = r_dn_wdata;
  assign AMCI_MOSI[RADDR +: AXI_ADDR_WIDTH] = r_dn_raddr;
  assign AMCI_MOSI[WRITE]                   = r_dn_write;
  assign AMCI_MOSI[READ]                    = r_dn_read;

  // A pulse only captures when its channel is free; set and clear masks can
  // never touch the same bit on one edge (clear needs pending=1, set needs 0).
  assign w_cap_w = w_wr_in & ~r_pend_w;
  assign w_cap_r = w_rd_in & ~r_pend_r;
  assign w_clr_w = w_w_done ? r_w_gnt : '0;
  assign w_clr_r = w_r_done ? r_r_gnt : '0;

  amci_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_w_arb (
    .req       (r_pend_w),
    .ptr       (r_w_ptr),
    .grant     (w_w_gnt),
    .grant_idx (w_w_gnt_idx)
  );

  amci_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_r_arb (
    .req       (r_pend_r),
    .ptr       (r_r_ptr),
    .grant     (w_r_gnt),
    .grant_idx (w_r_gnt_idx)
  );

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_pend_w <= '0;
      r_pend_r <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_waddr[i] <= '0;
        r_wdata[i] <= '0;
        r_raddr[i] <= '0;
        r_rdata[i] <= '0;
      end
    end else begin
      r_pend_w <= (r_pend_w | w_cap_w) & ~w_clr_w;
      r_pend_r <= (r_pend_r | w_cap_r) & ~w_clr_r;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_cap_w[i]) begin
          r_waddr[i] <= w_waddr_in[i];
          r_wdata[i] <= w_wdata_in[i];
        end
        if (w_cap_r[i]) begin
          r_raddr[i] <= w_raddr_in[i];
        end
        // Lands on the same edge pending_r clears, so ridle and rdata
        // become valid together.
        if (w_clr_r[i]) begin
          r_rdata[i] <= w_m_rdata;
        end
      end
    end
  end

  // Write channel FSM
  always_comb begin
    w_w_state_nxt = r_w_state;
    w_w_load      = 1'b0;
    w_w_done      = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        if ((|r_pend_w) && w_m_widle) begin
          w_w_load      = 1'b1;
          w_w_state_nxt = W_ISSUE;
        end
      end
      W_ISSUE: w_w_state_nxt = W_WAIT;
      W_WAIT: begin
        if (w_m_widle) begin
          w_w_done      = 1'b1;
          w_w_state_nxt = W_IDLE;
        end
      end
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  // Read channel FSM
  always_comb begin
    w_r_state_nxt = r_r_state;
    w_r_load      = 1'b0;
    w_r_done      = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        if ((|r_pend_r) && w_m_ridle) begin
          w_r_load      = 1'b1;
          w_r_state_nxt = R_ISSUE;
        end
      end
      R_ISSUE: w_r_state_nxt = R_WAIT;
      R_WAIT: begin
        if (w_m_ridle) begin
          w_r_done      = 1'b1;
          w_r_state_nxt = R_IDLE;
        end
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // The downstream pulse is a flop loaded on the IDLE->ISSUE edge, so it is
  // high for exactly the ISSUE cycle and never combinational from requesters.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_w_state  <= W_IDLE;
      r_r_state  <= R_IDLE;
      r_w_ptr    <= '0;
      r_r_ptr    <= '0;
      r_w_idx    <= '0;
      r_r_idx    <= '0;
      r_w_gnt    <= '0;
      r_r_gnt    <= '0;
      r_dn_waddr <= '0;
      r_dn_wdata <= '0;
      r_dn_raddr <= '0;
      r_dn_write <= 1'b0;
      r_dn_read  <= 1'b0;
    end else begin
      r_w_state  <= w_w_state_nxt;
      r_r_state  <= w_r_state_nxt;
      r_dn_write <= w_w_load;
      r_dn_read  <= w_r_load;
      if (w_w_load) begin
        r_w_gnt    <= w_w_gnt;
        r_w_idx    <= w_w_gnt_idx;
        r_dn_waddr <= r_waddr[w_w_gnt_idx];
        r_dn_wdata <= r_wdata[w_w_gnt_idx];
      end
      if (w_r_load) begin
        r_r_gnt    <= w_r_gnt;
        r_r_idx    <= w_r_gnt_idx;
        r_dn_raddr <= r_raddr[w_r_gnt_idx];
      end
      if (w_w_done) begin
        r_w_ptr <= ptr_after(r_w_idx);
      end
      if (w_r_done) begin
        r_r_ptr <= ptr_after(r_r_idx);
      end
    end
  end

endmodule
`default_nettype wire
